// File: rtl/dfisqr.sv
// Iterative packed-BCD squarer: builds the multiples M1..M9 of the operand, then
// accumulates acc = acc*10 + M(digit) once per operand digit, MSD first.
module dfisqr #(
  parameter int N = 25
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           ld,
  input  logic [N*4-1:0] a,
  output logic [N*8-1:0] o,
  output logic           done,
  output logic           err
);

  localparam int MW = (N + 1) * 4;
  localparam int AW = N * 8;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, PRE, MUL, FIN} state_t;

  state_t         r_state;
  logic [3:0]     r_k;
  logic [CW-1:0]  r_cnt;
  logic [N*4-1:0] r_q;
  logic [MW-1:0]  r_m [1:9];
  logic [AW-1:0]  r_acc;

  logic [3:0]     w_d;
  logic [MW-1:0]  w_md;
  logic [MW-1:0]  w_mprev;
  logic [MW-1:0]  w_msum;
  logic [AW-1:0]  w_acc_nx;
  logic           w_bad;

  function automatic logic [MW-1:0] bcd_add_m(input logic [MW-1:0] x, input logic [MW-1:0] y);
    logic [MW-1:0] r;
    logic [4:0]    s;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < N + 1; i++) begin
      s = {1'b0, x[4*i+:4]} + {1'b0, y[4*i+:4]} + {4'b0, c};
      c = (s > 5'd9);
      if (c) s = s + 5'd6;
      r[4*i+:4] = s[3:0];
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] bcd_add_acc(input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic [AW-1:0] r;
    logic [4:0]    s;
    logic          c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 2 * N; i++) begin
      s = {1'b0, x[4*i+:4]} + {1'b0, y[4*i+:4]} + {4'b0, c};
      c = (s > 5'd9);
      if (c) s = s + 5'd6;
      r[4*i+:4] = s[3:0];
    end
    return r;
  endfunction

  function automatic logic has_bad(input logic [N*4-1:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < N; i++) b = b | (v[4*i+:4] > 4'd9);
    return b;
  endfunction

  assign w_d   = r_q[N*4-1:N*4-4];
  assign w_bad = has_bad(a);

  // A non-decimal digit selects M0 = 0; the result is discarded via err anyway.
  always_comb begin
    w_md = '0;
    if (w_d >= 4'd1 && w_d <= 4'd9) w_md = r_m[w_d];
    w_mprev = '0;
    if (r_k >= 4'd2 && r_k <= 4'd9) w_mprev = r_m[r_k - 4'd1];
  end

  assign w_msum   = bcd_add_m(w_mprev, r_m[1]);
  assign w_acc_nx = bcd_add_acc({r_acc[AW-5:0], 4'h0}, {{(AW-MW){1'b0}}, w_md});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      for (int i = 1; i <= 9; i++) r_m[i] <= '0;
      o       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else if (ce) begin
      if (ld) begin
        r_m[1]  <= {4'h0, a};
        r_q     <= a;
        r_acc   <= '0;
        done    <= 1'b0;
        err     <= w_bad;
        r_k     <= 4'd2;
        r_state <= PRE;
      end else begin
        case (r_state)
          PRE: begin
            r_m[r_k] <= w_msum;
            r_k      <= r_k + 4'd1;
            if (r_k == 4'd9) begin
              r_state <= MUL;
              r_cnt   <= CW'(N - 1);
            end
          end
          MUL: begin
            r_acc <= w_acc_nx;
            r_q   <= {r_q[N*4-5:0], 4'h0};
            if (r_cnt == '0) begin
              r_state <= FIN;
              o       <= err ? '0 : w_acc_nx;
              done    <= 1'b1;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dfisqr.sv
// Bench for dfisqr: directed N=4 scenarios plus randomized N=25 squares checked
// against a decimal big-integer reference.
module tb_dfisqr;

  localparam int NB = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              ce4, ld4, done4, err4;
  logic [15:0]       a4;
  logic [31:0]       o4;
  logic              ce25, ld25, done25, err25;
  logic [NB*4-1:0]   a25;
  logic [NB*8-1:0]   o25;

  int n_checks = 0;
  int n_pass   = 0;

  dfisqr #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .ce(ce4), .ld(ld4), .a(a4),
    .o(o4), .done(done4), .err(err4)
  );

  dfisqr #(.N(NB)) u_dut25 (
    .clk(clk), .rst(rst), .ce(ce25), .ld(ld25), .a(a25),
    .o(o25), .done(done25), .err(err25)
  );

  // Schoolbook decimal multiplication on digit arrays, then carry normalisation.
  function automatic logic [NB*8-1:0] ref_sq(input logic [NB*4-1:0] v);
    int d[NB];
    int p[2*NB];
    int c, t;
    logic [NB*8-1:0] r;
    for (int i = 0; i < NB; i++) d[i] = int'(v[4*i+:4]);
    for (int i = 0; i < 2 * NB; i++) p[i] = 0;
    for (int i = 0; i < NB; i++)
      for (int j = 0; j < NB; j++) p[i+j] += d[i] * d[j];
    c = 0;
    r = '0;
    for (int k = 0; k < 2 * NB; k++) begin
      t = p[k] + c;
      r[4*k+:4] = 4'(t % 10);
      c = t / 10;
    end
    return r;
  endfunction

  function automatic logic [NB*4-1:0] rand_bcd25();
    logic [NB*4-1:0] v;
    for (int i = 0; i < NB; i++) v[4*i+:4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  function automatic logic [NB*4-1:0] fill25(input logic [3:0] dg);
    logic [NB*4-1:0] v;
    for (int i = 0; i < NB; i++) v[4*i+:4] = dg;
    return v;
  endfunction

  task automatic start4(input logic [15:0] v);
    a4 = v; ld4 = 1'b1; ce4 = 1'b1;
    @(posedge clk); #1;
    ld4 = 1'b0;
  endtask

  task automatic wait4(output int e);
    e = 0;
    while (!done4 && e < 60) begin @(posedge clk); #1; e++; end
  endtask

  task automatic start25(input logic [NB*4-1:0] v);
    a25 = v; ld25 = 1'b1; ce25 = 1'b1;
    @(posedge clk); #1;
    ld25 = 1'b0;
  endtask

  task automatic wait25(output int e);
    e = 0;
    while (!done25 && e < 100) begin @(posedge clk); #1; e++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce4 = 1'b1; ld4 = 1'b1; a4 = 16'h9999;
    ce25 = 1'b1; ld25 = 1'b1; a25 = fill25(4'h9);
    #3 rst = 1'b0;
    #1;
    n_checks++;
    if ({o4, done4, err4} !== 34'h0) $display("FAIL reset4: got o=%h done=%b err=%b want 0", o4, done4, err4);
    else n_pass++;
    n_checks++;
    if (o25 !== '0 || done25 !== 1'b0 || err25 !== 1'b0)
      $display("FAIL reset25: got o=%h done=%b err=%b want 0", o25, done25, err25);
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({o4, done4, err4} !== 34'h0) $display("FAIL reset_held: got o=%h done=%b err=%b want 0", o4, done4, err4);
    else n_pass++;
    ld4 = 1'b0; ld25 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done4 !== 1'b0 || done25 !== 1'b0) $display("FAIL idle_no_done: got done4=%b done25=%b want 0", done4, done25);
    else n_pass++;
  endtask

  task automatic test_basic();
    int e;
    logic ok;
    start4(16'h9999);
    wait4(e);
    n_checks++;
    if (e != 12) $display("FAIL latency_9999: got %0d edges want 12", e);
    else n_pass++;
    n_checks++;
    if (o4 !== 32'h99980001 || err4 !== 1'b0) $display("FAIL sq_9999: got o=%h err=%b want 99980001 err=0", o4, err4);
    else n_pass++;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done4 !== 1'b1 || o4 !== 32'h99980001) ok = 1'b0;
    end
    n_checks++;
    if (!ok) $display("FAIL fin_hold: got done=%b o=%h want done=1 o=99980001", done4, o4);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] av [3] = '{16'h1234, 16'h0000, 16'h0001};
    logic [31:0] ov [3] = '{32'h01522756, 32'h00000000, 32'h00000001};
    int e;
    for (int i = 0; i < 3; i++) begin
      start4(av[i]);
      wait4(e);
      n_checks++;
      if (e != 12 || o4 !== ov[i])
        $display("FAIL b2b_%0d: got edges=%0d o=%h want edges=12 o=%h", i, e, o4, ov[i]);
      else n_pass++;
    end
  endtask

  task automatic test_restart();
    int e;
    logic ok;
    start4(16'h5000);
    ok = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (done4 !== 1'b0) ok = 1'b0; end
    start4(16'h0003);
    n_checks++;
    if (!ok || done4 !== 1'b0) $display("FAIL restart_no_done: got done=%b ok=%b want done=0", done4, ok);
    else n_pass++;
    wait4(e);
    n_checks++;
    if (e != 12 || o4 !== 32'h00000009)
      $display("FAIL restart_result: got edges=%0d o=%h want edges=12 o=00000009", e, o4);
    else n_pass++;
  endtask

  task automatic test_ce_gating();
    int ce_edges, k;
    start4(16'h0707);
    ce_edges = 0;
    k = 0;
    while (!done4 && k < 100) begin
      ce4 = k[0];
      ld4 = (k == 4);
      a4  = (k == 4) ? 16'h9999 : 16'h0707;
      @(posedge clk); #1;
      if (ce4) ce_edges++;
      k++;
    end
    ce4 = 1'b1; ld4 = 1'b0; a4 = 16'h0707;
    n_checks++;
    if (ce_edges != 12 || o4 !== 32'h00499849)
      $display("FAIL ce_gating: got ce_edges=%0d o=%h want 12 o=00499849", ce_edges, o4);
    else n_pass++;
  endtask

  task automatic test_err();
    int e;
    start4(16'h12A4);
    n_checks++;
    if (err4 !== 1'b1 || done4 !== 1'b0) $display("FAIL err_set: got err=%b done=%b want err=1 done=0", err4, done4);
    else n_pass++;
    wait4(e);
    n_checks++;
    if (e != 12 || o4 !== 32'h0 || err4 !== 1'b1)
      $display("FAIL err_result: got edges=%0d o=%h err=%b want 12 o=0 err=1", e, o4, err4);
    else n_pass++;
    start4(16'h0001);
    n_checks++;
    if (err4 !== 1'b0) $display("FAIL err_clear: got err=%b want 0", err4);
    else n_pass++;
    wait4(e);
    n_checks++;
    if (e != 12 || o4 !== 32'h1) $display("FAIL err_recover: got edges=%0d o=%h want 12 o=00000001", e, o4);
    else n_pass++;
  endtask

  task automatic test_random25();
    logic [NB*4-1:0] v;
    logic [NB*8-1:0] exp_o;
    int e;
    for (int i = 0; i < 503; i++) begin
      if (i == 0) v = fill25(4'h9);
      else if (i == 1) v = '0;
      else if (i == 2) v = fill25(4'h0) | 100'h1;
      else v = rand_bcd25();
      exp_o = ref_sq(v);
      start25(v);
      wait25(e);
      n_checks++;
      if (e != NB + 8 || o25 !== exp_o || err25 !== 1'b0)
        $display("FAIL rand25_%0d: a=%h got edges=%0d o=%h err=%b want edges=%0d o=%h", i, v, e, o25, err25, NB + 8, exp_o);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [NB*4-1:0] v;
    logic [NB*8-1:0] exp_o;
    logic ok;
    int e;
    v = fill25(4'h7);
    exp_o = ref_sq(v);
    start25(v);
    wait25(e);
    v = rand_bcd25();
    v[NB*4-1:NB*4-4] = 4'hF;
    start25(v);
    repeat (19) @(posedge clk);
    #1;
    n_checks++;
    if (o25 !== exp_o || err25 !== 1'b1 || done25 !== 1'b0)
      $display("FAIL pre_reset_state: got o=%h err=%b done=%b want o=%h err=1 done=0", o25, err25, done25, exp_o);
    else n_pass++;
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (o25 !== '0 || done25 !== 1'b0 || err25 !== 1'b0)
      $display("FAIL async_reset: got o=%h done=%b err=%b want 0", o25, done25, err25);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    ok = 1'b1;
    repeat (50) begin @(posedge clk); #1; if (done25 !== 1'b0) ok = 1'b0; end
    n_checks++;
    if (!ok) $display("FAIL no_done_after_reset: got done=%b want 0", done25);
    else n_pass++;
    v = rand_bcd25();
    exp_o = ref_sq(v);
    start25(v);
    wait25(e);
    n_checks++;
    if (e != NB + 8 || o25 !== exp_o)
      $display("FAIL post_reset_run: got edges=%0d o=%h want edges=%0d o=%h", e, o25, NB + 8, exp_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_restart();
    test_ce_gating();
    test_err();
    test_random25();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
